// File: rtl/message_queue_param.sv
// Circular queue of whole packets, drained as WISHBONE bursts with a beat-pointer FSM.
// Optional statistics ports/counters are built when MSG_QUEUE_STATS_EN is defined.
module message_queue_param #(
  parameter int DEPTH        = 8,
  parameter int PTR_W        = 3,
  parameter int FLIT_W       = 64,
  parameter int MAX_PKT_LEN  = 5,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int SEL_W        = 4,
  parameter int BURST_W      = 7,
  parameter int CMD_READ_BIT = 63
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAX_PKT_LEN*FLIT_W-1:0] in_link_i,
  input  logic [MAX_PKT_LEN-1:0]        in_sel_i,
  input  logic                          r_pkt_to_msg_i,
  output logic                          g_pkt_to_msg_o,
  output logic                          r_bus_arbitration_o,
  output logic [ADDR_W-1:0]             address_o,
  output logic [DATA_W-1:0]             data_o,
  output logic [SEL_W-1:0]              sel_o,
  output logic                          transaction_type_o,
  output logic [BURST_W-1:0]            burst_lenght_o,
  input  logic                          next_data_i,
  input  logic                          retry_i,
  input  logic                          message_transmitted_i,
  output logic [PTR_W:0]                occupancy_o,
  output logic                          full_o,
  output logic                          empty_o
`ifdef MSG_QUEUE_STATS_EN
  ,
  output logic [15:0]                   tx_count_o,
  output logic [15:0]                   retry_count_o
`endif
);

  localparam int WORDS_PER_FLIT = FLIT_W / DATA_W;
  localparam int PAY_W          = (MAX_PKT_LEN - 1) * FLIT_W;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} beat_state_e;

  function automatic logic [BURST_W-1:0] payload_beats(input logic [MAX_PKT_LEN-1:0] sel);
    logic [BURST_W-1:0] beats;
    beats = {BURST_W{1'b0}};
    for (int k = 1; k < MAX_PKT_LEN; k++) begin
      if (sel[k]) beats = beats + BURST_W'(WORDS_PER_FLIT);
    end
    return beats;
  endfunction

  logic [FLIT_W-1:0]  head_mem    [DEPTH];
  logic [PAY_W-1:0]   pay_mem     [DEPTH];
  logic [BURST_W-1:0] burst_mem   [DEPTH];
  logic               write_mem   [DEPTH];
  logic               payload_mem [DEPTH];

  logic               grant_q, grant_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]     occ_q, occ_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  beat_state_e        state_q, state_d;

  logic               push_s, pop_s;
  logic [FLIT_W-1:0]  head_in_s, head_flit_s;
  logic [PAY_W-1:0]   pay_head_s;
  logic               is_read_s, has_payload_s;
  logic [BURST_W-1:0] burst_in_s, head_burst_s;
  logic               unused_head_s;

  assign occupancy_o    = occ_q;
  assign empty_o        = (occ_q == {(PTR_W+1){1'b0}});
  assign full_o         = (occ_q == (PTR_W+1)'(DEPTH));
  assign g_pkt_to_msg_o = grant_q;
  assign head_in_s      = in_link_i[FLIT_W-1:0];

  always_comb begin
    is_read_s     = (in_sel_i == MAX_PKT_LEN'(1)) && head_in_s[CMD_READ_BIT];
    has_payload_s = |in_sel_i[MAX_PKT_LEN-1:1];
    if (is_read_s || !has_payload_s) begin
      burst_in_s = BURST_W'(1);
    end else begin
      burst_in_s = payload_beats(in_sel_i);
    end
  end

  // Grant is taken against the pre-pop full flag; the entry is written on the grant cycle.
  always_comb begin
    push_s  = grant_q;
    pop_s   = message_transmitted_i & ~empty_o;
    grant_d = r_pkt_to_msg_i & ~full_o & ~grant_q;
    if (push_s) begin
      tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = (head_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    if (occ_d == {(PTR_W+1){1'b0}}) begin
      state_d = ST_IDLE;
    end else begin
      state_d = ST_BURST;
    end
    beat_d = beat_q;
    case (state_q)
      ST_BURST: begin
        if (pop_s || retry_i) begin
          beat_d = {BURST_W{1'b0}};
        end else if (next_data_i && ((beat_q + BURST_W'(1)) < head_burst_s)) begin
          beat_d = beat_q + BURST_W'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      ST_IDLE: beat_d = {BURST_W{1'b0}};
      default: beat_d = {BURST_W{1'b0}};
    endcase
  end

  always_comb begin
    head_flit_s   = head_mem[head_q];
    pay_head_s    = pay_mem[head_q];
    head_burst_s  = burst_mem[head_q];
    unused_head_s = ^head_flit_s;
    if (empty_o) begin
      address_o           = {ADDR_W{1'b0}};
      data_o              = {DATA_W{1'b0}};
      sel_o               = {SEL_W{1'b0}};
      transaction_type_o  = 1'b0;
      burst_lenght_o      = {BURST_W{1'b0}};
      r_bus_arbitration_o = 1'b0;
    end else begin
      address_o           = head_flit_s[ADDR_W-1:0];
      sel_o               = {SEL_W{1'b1}};
      transaction_type_o  = write_mem[head_q];
      burst_lenght_o      = head_burst_s;
      r_bus_arbitration_o = 1'b1;
      if (write_mem[head_q] && payload_mem[head_q]) begin
        data_o = pay_head_s[beat_q*DATA_W +: DATA_W];
      end else begin
        data_o = head_flit_s[DATA_W-1:0];
      end
    end
  end

  // Entry storage carries no reset; only the pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (push_s) begin
      head_mem[tail_q]    <= head_in_s;
      pay_mem[tail_q]     <= in_link_i[MAX_PKT_LEN*FLIT_W-1:FLIT_W];
      burst_mem[tail_q]   <= burst_in_s;
      write_mem[tail_q]   <= ~is_read_s;
      payload_mem[tail_q] <= has_payload_s & ~is_read_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= 1'b0;
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      occ_q   <= {(PTR_W+1){1'b0}};
      beat_q  <= {BURST_W{1'b0}};
      state_q <= ST_IDLE;
    end else begin
      grant_q <= grant_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      beat_q  <= beat_d;
      state_q <= state_d;
    end
  end

`ifdef MSG_QUEUE_STATS_EN
  logic [15:0] tx_count_q, tx_count_d, retry_count_q, retry_count_d;

  always_comb begin
    if (pop_s && (tx_count_q != 16'hFFFF)) begin
      tx_count_d = tx_count_q + 16'd1;
    end else begin
      tx_count_d = tx_count_q;
    end
    if (retry_i && !empty_o && (retry_count_q != 16'hFFFF)) begin
      retry_count_d = retry_count_q + 16'd1;
    end else begin
      retry_count_d = retry_count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_count_q    <= 16'd0;
      retry_count_q <= 16'd0;
    end else begin
      tx_count_q    <= tx_count_d;
      retry_count_q <= retry_count_d;
    end
  end

  assign tx_count_o    = tx_count_q;
  assign retry_count_o = retry_count_q;
`endif

endmodule

// File: tb/tb_message_queue_param.sv
// Directed self-checking bench for message_queue_param (default parameters).
module tb_message_queue_param;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [319:0] in_link_i = '0;
  logic [4:0]   in_sel_i = '0;
  logic         r_pkt_to_msg_i = 1'b0;
  logic         g_pkt_to_msg_o, r_bus_arbitration_o, transaction_type_o;
  logic [31:0]  address_o, data_o;
  logic [3:0]   sel_o;
  logic [6:0]   burst_lenght_o;
  logic         next_data_i = 1'b0, retry_i = 1'b0, message_transmitted_i = 1'b0;
  logic [3:0]   occupancy_o;
  logic         full_o, empty_o;
`ifdef MSG_QUEUE_STATS_EN
  logic [15:0]  tx_count_o, retry_count_o;
`endif

  int total = 0;
  int bad = 0;

  message_queue_param dut (
    .clk(clk), .rst(rst), .in_link_i(in_link_i), .in_sel_i(in_sel_i),
    .r_pkt_to_msg_i(r_pkt_to_msg_i), .g_pkt_to_msg_o(g_pkt_to_msg_o),
    .r_bus_arbitration_o(r_bus_arbitration_o), .address_o(address_o), .data_o(data_o),
    .sel_o(sel_o), .transaction_type_o(transaction_type_o), .burst_lenght_o(burst_lenght_o),
    .next_data_i(next_data_i), .retry_i(retry_i), .message_transmitted_i(message_transmitted_i),
    .occupancy_o(occupancy_o), .full_o(full_o), .empty_o(empty_o)
`ifdef MSG_QUEUE_STATS_EN
    , .tx_count_o(tx_count_o), .retry_count_o(retry_count_o)
`endif
  );

  always #5 clk = ~clk;

  // Head flit = {cmd, 31'b0, addr}; payload word p = base + p.
  function automatic logic [319:0] make_pkt(input logic cmd, input logic [31:0] addr, input logic [31:0] base);
    logic [319:0] l;
    l = '0;
    l[63] = cmd;
    l[31:0] = addr;
    for (int p = 0; p < 8; p++) l[64 + p*32 +: 32] = base + 32'(p);
    return l;
  endfunction

  task automatic send_pkt(input logic [319:0] link, input logic [4:0] sel);
    in_link_i = link; in_sel_i = sel; r_pkt_to_msg_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    r_pkt_to_msg_i = 1'b0;
  endtask

  task automatic pulse_next();  next_data_i = 1'b1; @(negedge clk); next_data_i = 1'b0; endtask
  task automatic pulse_retry(); retry_i = 1'b1; @(negedge clk); retry_i = 1'b0; endtask
  task automatic pulse_pop();   message_transmitted_i = 1'b1; @(negedge clk); message_transmitted_i = 1'b0; endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (occupancy_o !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy_o); end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty_o); end
    total++; if (full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full_o); end
    total++; if (g_pkt_to_msg_o !== 1'b0) begin bad++; $display("FAIL reset_grant got=%b want=0", g_pkt_to_msg_o); end
    total++; if (r_bus_arbitration_o !== 1'b0) begin bad++; $display("FAIL reset_busreq got=%b want=0", r_bus_arbitration_o); end
    total++; if (burst_lenght_o !== 7'd0 || sel_o !== 4'h0) begin bad++; $display("FAIL reset_burst_sel got=%0d/%h want=0/0", burst_lenght_o, sel_o); end
`ifdef MSG_QUEUE_STATS_EN
    total++; if (tx_count_o !== 16'd0 || retry_count_o !== 16'd0) begin bad++; $display("FAIL reset_stats got=%0d/%0d want=0/0", tx_count_o, retry_count_o); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_burst();
    logic [31:0] want;
    in_link_i = make_pkt(1'b0, 32'hDEAD_0000, 32'h1000_0000); in_sel_i = 5'b11111; r_pkt_to_msg_i = 1'b1;
    @(negedge clk);
    total++; if (g_pkt_to_msg_o !== 1'b1) begin bad++; $display("FAIL grant_latency got=%b want=1", g_pkt_to_msg_o); end
    @(negedge clk);
    total++; if (g_pkt_to_msg_o !== 1'b0) begin bad++; $display("FAIL grant_no_repeat got=%b want=0", g_pkt_to_msg_o); end
    r_pkt_to_msg_i = 1'b0;
    total++; if (occupancy_o !== 4'd1 || empty_o !== 1'b0) begin bad++; $display("FAIL push_occ got=%0d/%b want=1/0", occupancy_o, empty_o); end
    total++; if (r_bus_arbitration_o !== 1'b1) begin bad++; $display("FAIL push_busreq got=%b want=1", r_bus_arbitration_o); end
    total++; if (burst_lenght_o !== 7'd8) begin bad++; $display("FAIL wr_burst got=%0d want=8", burst_lenght_o); end
    total++; if (transaction_type_o !== 1'b1) begin bad++; $display("FAIL wr_type got=%b want=1", transaction_type_o); end
    total++; if (address_o !== 32'hDEAD_0000) begin bad++; $display("FAIL wr_addr got=%h want=dead0000", address_o); end
    total++; if (sel_o !== 4'hF) begin bad++; $display("FAIL wr_sel got=%h want=f", sel_o); end
    total++; if (data_o !== 32'h1000_0000) begin bad++; $display("FAIL wr_beat0 got=%h want=10000000", data_o); end
    for (int i = 1; i <= 8; i++) begin
      pulse_next();
      want = 32'h1000_0000 + 32'((i > 7) ? 7 : i);
      total++; if (data_o !== want) begin bad++; $display("FAIL wr_beat%0d got=%h want=%h", i, data_o, want); end
    end
    pulse_pop();
    total++; if (empty_o !== 1'b1 || occupancy_o !== 4'd0 || r_bus_arbitration_o !== 1'b0) begin bad++; $display("FAIL wr_pop got=%b/%0d/%b want=1/0/0", empty_o, occupancy_o, r_bus_arbitration_o); end
    total++; if (burst_lenght_o !== 7'd0 || sel_o !== 4'h0) begin bad++; $display("FAIL empty_burst_sel got=%0d/%h want=0/0", burst_lenght_o, sel_o); end
  endtask

  task automatic test_read_ctrl();
    logic        cmd [3]   = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  sel [3]   = '{5'b00001, 5'b00001, 5'b00011};
    logic [31:0] addr [3]  = '{32'h1234_5678, 32'h0BAD_F00D, 32'h4444_0000};
    logic        typ [3]   = '{1'b0, 1'b1, 1'b1};
    logic [6:0]  bl [3]    = '{7'd1, 7'd1, 7'd2};
    logic [31:0] d0 [3]    = '{32'h1234_5678, 32'h0BAD_F00D, 32'h3000_0000};
    logic [31:0] d1 [3]    = '{32'h1234_5678, 32'h0BAD_F00D, 32'h3000_0001};
    for (int v = 0; v < 3; v++) begin
      send_pkt(make_pkt(cmd[v], addr[v], 32'h3000_0000), sel[v]);
      total++; if (transaction_type_o !== typ[v]) begin bad++; $display("FAIL rc%0d_type got=%b want=%b", v, transaction_type_o, typ[v]); end
      total++; if (burst_lenght_o !== bl[v]) begin bad++; $display("FAIL rc%0d_burst got=%0d want=%0d", v, burst_lenght_o, bl[v]); end
      total++; if (data_o !== d0[v] || address_o !== addr[v]) begin bad++; $display("FAIL rc%0d_data got=%h/%h want=%h/%h", v, data_o, address_o, d0[v], addr[v]); end
      pulse_next();
      pulse_next();
      total++; if (data_o !== d1[v]) begin bad++; $display("FAIL rc%0d_sat got=%h want=%h", v, data_o, d1[v]); end
      pulse_pop();
    end
    pulse_pop();
    total++; if (occupancy_o !== 4'd0 || empty_o !== 1'b1) begin bad++; $display("FAIL pop_when_empty got=%0d/%b want=0/1", occupancy_o, empty_o); end
  endtask

  task automatic test_retry();
    send_pkt(make_pkt(1'b0, 32'h0000_4000, 32'h4000_0000), 5'b11111);
    repeat (5) pulse_next();
    total++; if (data_o !== 32'h4000_0005) begin bad++; $display("FAIL retry_beat5 got=%h want=40000005", data_o); end
    pulse_retry();
    total++; if (data_o !== 32'h4000_0000) begin bad++; $display("FAIL retry_to0 got=%h want=40000000", data_o); end
    pulse_next();
    total++; if (data_o !== 32'h4000_0001) begin bad++; $display("FAIL retry_then_next got=%h want=40000001", data_o); end
    pulse_pop();
  endtask

  task automatic test_full_wrap();
    for (int j = 0; j < 8; j++) send_pkt(make_pkt(1'b0, 32'hA000_0000 + 32'(j), 32'h5000_0000 + 32'(j*256)), 5'b11111);
    total++; if (occupancy_o !== 4'd8 || full_o !== 1'b1) begin bad++; $display("FAIL fill_full got=%0d/%b want=8/1", occupancy_o, full_o); end
    in_link_i = make_pkt(1'b0, 32'hA000_0008, 32'h5000_0800); in_sel_i = 5'b11111; r_pkt_to_msg_i = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (g_pkt_to_msg_o !== 1'b0) begin bad++; $display("FAIL full_grant_held got=%b want=0", g_pkt_to_msg_o); end
    pulse_pop();
    total++; if (g_pkt_to_msg_o !== 1'b0 || occupancy_o !== 4'd7) begin bad++; $display("FAIL pop_cycle_grant got=%b/%0d want=0/7", g_pkt_to_msg_o, occupancy_o); end
    @(negedge clk);
    total++; if (g_pkt_to_msg_o !== 1'b1) begin bad++; $display("FAIL grant_after_pop got=%b want=1", g_pkt_to_msg_o); end
    r_pkt_to_msg_i = 1'b0;
    @(negedge clk);
    total++; if (occupancy_o !== 4'd8 || full_o !== 1'b1) begin bad++; $display("FAIL refill got=%0d/%b want=8/1", occupancy_o, full_o); end
    for (int j = 1; j <= 8; j++) begin
      total++;
      if (data_o !== 32'h5000_0000 + 32'(j*256) || address_o !== 32'hA000_0000 + 32'(j) || burst_lenght_o !== 7'd8) begin
        bad++; $display("FAIL wrap_entry%0d got=%h/%h/%0d want=%h/%h/8", j, data_o, address_o, burst_lenght_o, 32'h5000_0000 + 32'(j*256), 32'hA000_0000 + 32'(j));
      end
      pulse_pop();
    end
    total++; if (empty_o !== 1'b1 || occupancy_o !== 4'd0) begin bad++; $display("FAIL drain_empty got=%b/%0d want=1/0", empty_o, occupancy_o); end
  endtask

  task automatic test_reset_mid_burst();
    send_pkt(make_pkt(1'b0, 32'h0000_6000, 32'h6000_0000), 5'b11111);
    repeat (2) pulse_next();
    total++; if (data_o !== 32'h6000_0002) begin bad++; $display("FAIL mid_beat2 got=%h want=60000002", data_o); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (occupancy_o !== 4'd0 || empty_o !== 1'b1 || g_pkt_to_msg_o !== 1'b0 || r_bus_arbitration_o !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%0d/%b/%b/%b want=0/1/0/0", occupancy_o, empty_o, g_pkt_to_msg_o, r_bus_arbitration_o);
    end
    rst = 1'b0;
    @(negedge clk);
    send_pkt(make_pkt(1'b0, 32'h0000_7000, 32'h7000_0000), 5'b11111);
    total++; if (data_o !== 32'h7000_0000 || occupancy_o !== 4'd1) begin bad++; $display("FAIL post_reset_push got=%h/%0d want=70000000/1", data_o, occupancy_o); end
    pulse_pop();
  endtask

`ifdef MSG_QUEUE_STATS_EN
  task automatic test_stats();
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    pulse_retry();
    for (int j = 0; j < 3; j++) send_pkt(make_pkt(1'b0, 32'(j), 32'h8000_0000), 5'b00011);
    pulse_retry();
    pulse_retry();
    repeat (3) pulse_pop();
    pulse_pop();
    total++; if (tx_count_o !== 16'd3) begin bad++; $display("FAIL stats_tx got=%0d want=3", tx_count_o); end
    total++; if (retry_count_o !== 16'd2) begin bad++; $display("FAIL stats_retry got=%0d want=2", retry_count_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_burst();
    test_read_ctrl();
    test_retry();
    test_full_wrap();
    test_reset_mid_burst();
`ifdef MSG_QUEUE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
